// File: rtl/fast_square_unpack.sv
// Unpacks 16-bit packed I/Q sign words from a small FIFO into one signed I/Q
// sample pair per clock; an all-channel marker word flushes and resynchronizes.
module fast_square_unpack #(
    parameter logic signed [15:0] AMPLITUDE  = 16'sd8192,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [15:0]        MARKER     = 16'h8000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_strobe,
    input  logic [15:0]        i_in,
    input  logic [15:0]        q_in,
    output logic               in_ready,
    output logic               out_strobe,
    output logic signed [15:0] i_out,
    output logic signed [15:0] q_out,
    output logic               underrun,
    output logic               overflow
);

    localparam int unsigned       PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned       CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic signed [15:0] POS_C  = AMPLITUDE;
    localparam logic signed [15:0] NEG_C  = -AMPLITUDE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0]       wrPtr_q, wrPtr_d;
    logic [PW-1:0]       rdPtr_q, rdPtr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [15:0]         shiftI_q, shiftI_d;
    logic [15:0]         shiftQ_q, shiftQ_d;
    logic [3:0]          bitCnt_q, bitCnt_d;
    logic                outStrobe_q, outStrobe_d;
    logic signed [15:0]  iOut_q, iOut_d;
    logic signed [15:0]  qOut_q, qOut_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;

    logic                isMarker;
    logic                notFull;
    logic                wrEn;
    logic                rdEn;
    logic                flush;
    logic [31:0]         rdData;

    function automatic logic signed [15:0] toSample(input logic b);
        return b ? POS_C : NEG_C;
    endfunction

    assign isMarker = in_strobe && (i_in == MARKER) && (q_in == MARKER);
    assign notFull  = count_q < DEPTH_C;
    assign in_ready = notFull;
    assign rdData   = fifoMem_q[rdPtr_q];

    // bitCnt_q is the index of the bit currently on the outputs; at 15 the word is spent
    always_comb begin
        state_d     = state_q;
        shiftI_d    = shiftI_q;
        shiftQ_d    = shiftQ_q;
        bitCnt_d    = bitCnt_q;
        outStrobe_d = 1'b0;
        iOut_d      = '0;
        qOut_d      = '0;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q;
        wrEn        = 1'b0;
        rdEn        = 1'b0;
        flush       = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            flush      = 1'b1;
            underrun_d = 1'b0;
            overflow_d = 1'b0;
            shiftI_d   = '0;
            shiftQ_d   = '0;
            bitCnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                    flush   = 1'b1;
                end
                FILL, RUN: begin
                    if (isMarker) begin
                        flush    = 1'b1;
                        shiftI_d = '0;
                        shiftQ_d = '0;
                        bitCnt_d = '0;
                        state_d  = FILL;
                    end else begin
                        if (in_strobe) begin
                            if (notFull) begin
                                wrEn = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                        if (state_q == FILL) begin
                            if (count_q >= CW'(2)) begin
                                rdEn = 1'b1;
                            end
                        end else if (bitCnt_q != 4'd15) begin
                            outStrobe_d = 1'b1;
                            iOut_d      = toSample(shiftI_q[15]);
                            qOut_d      = toSample(shiftQ_q[15]);
                            shiftI_d    = {shiftI_q[14:0], 1'b0};
                            shiftQ_d    = {shiftQ_q[14:0], 1'b0};
                            bitCnt_d    = bitCnt_q + 4'd1;
                        end else if (count_q != '0) begin
                            rdEn = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = FILL;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end
            endcase

            // A popped word drives its oldest bit immediately; the rest waits in the shifter
            if (rdEn) begin
                state_d     = RUN;
                outStrobe_d = 1'b1;
                iOut_d      = toSample(rdData[31]);
                qOut_d      = toSample(rdData[15]);
                shiftI_d    = {rdData[30:16], 1'b0};
                shiftQ_d    = {rdData[14:0], 1'b0};
                bitCnt_d    = '0;
            end
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrEn) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (rdEn) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({wrEn, rdEn})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            shiftI_q    <= '0;
            shiftQ_q    <= '0;
            bitCnt_q    <= '0;
            outStrobe_q <= 1'b0;
            iOut_q      <= '0;
            qOut_q      <= '0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            shiftI_q    <= shiftI_d;
            shiftQ_q    <= shiftQ_d;
            bitCnt_q    <= bitCnt_d;
            outStrobe_q <= outStrobe_d;
            iOut_q      <= iOut_d;
            qOut_q      <= qOut_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wrEn) begin
            fifoMem_q[wrPtr_q] <= {i_in, q_in};
        end
    end

    assign out_strobe = outStrobe_q;
    assign i_out      = iOut_q;
    assign q_out      = qOut_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fast_square_unpack.sv
// Self-checking bench for fast_square_unpack: table vectors, directed corner
// sequences and random traffic against a queue-based behavioural model.
module tb_fast_square_unpack;

    localparam int DEPTH = 4;
    localparam logic signed [15:0] AMP  = 16'sd8192;
    localparam logic signed [15:0] NAMP = -16'sd8192;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               in_strobe;
    logic [15:0]        i_in;
    logic [15:0]        q_in;
    logic               in_ready;
    logic               out_strobe;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               underrun;
    logic               overflow;

    fast_square_unpack dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .in_strobe  (in_strobe),
        .i_in       (i_in),
        .q_in       (q_in),
        .in_ready   (in_ready),
        .out_strobe (out_strobe),
        .i_out      (i_out),
        .q_out      (q_out),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int strobeCount = 0;
    logic [31:0] gotQ[$];

    // Model: mode 0 idle / 1 waiting for data / 2 streaming; mPos = bits of mCur already sent
    int                 mMode;
    logic [31:0]        mQ[$];
    logic [31:0]        mCur;
    int                 mPos;
    logic               mStrobe;
    logic               mUnf;
    logic               mOvf;
    logic signed [15:0] mI;
    logic signed [15:0] mQout;

    function automatic void modelReset();
        mMode = 0;
        mQ.delete();
        mCur = '0;
        mPos = 0;
        mStrobe = 1'b0;
        mUnf = 1'b0;
        mOvf = 1'b0;
        mI = '0;
        mQout = '0;
    endfunction

    function automatic void modelStep(input logic en, input logic st,
                                      input logic [15:0] ii, input logic [15:0] qq);
        int pre;
        logic doPop;
        logic [31:0] w;
        mStrobe = 1'b0;
        mI = '0;
        mQout = '0;
        w = '0;
        if (!en) begin
            mMode = 0;
            mQ.delete();
            mUnf = 1'b0;
            mOvf = 1'b0;
        end else if (mMode == 0) begin
            mMode = 1;
            mQ.delete();
        end else if (st && ii == 16'h8000 && qq == 16'h8000) begin
            mQ.delete();
            mMode = 1;
        end else begin
            pre = mQ.size();
            if (mMode == 1) doPop = (pre >= 2);
            else doPop = (mPos == 16) && (pre > 0);
            if (doPop) w = mQ.pop_front();
            if (st) begin
                if (pre < DEPTH) mQ.push_back({ii, qq});
                else mOvf = 1'b1;
            end
            if (doPop) begin
                mCur = w;
                mPos = 0;
                mMode = 2;
            end
            if (mMode == 2) begin
                if (mPos < 16) begin
                    mStrobe = 1'b1;
                    mI = mCur[31 - mPos] ? AMP : NAMP;
                    mQout = mCur[15 - mPos] ? AMP : NAMP;
                    mPos++;
                end else begin
                    mUnf = 1'b1;
                    mMode = 1;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name);
        logic expRdy;
        expRdy = (mQ.size() < DEPTH);
        vectors++;
        if (out_strobe !== mStrobe || i_out !== mI || q_out !== mQout ||
            underrun !== mUnf || overflow !== mOvf || in_ready !== expRdy) begin
            miscompares++;
            $display("FAIL %s @%0t: got stb=%b i=%0d q=%0d unf=%b ovf=%b rdy=%b, want stb=%b i=%0d q=%0d unf=%b ovf=%b rdy=%b",
                     name, $time, out_strobe, i_out, q_out, underrun, overflow, in_ready,
                     mStrobe, mI, mQout, mUnf, mOvf, expRdy);
        end
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic st,
                                 input logic [15:0] ii, input logic [15:0] qq);
        enable = en;
        in_strobe = st;
        i_in = ii;
        q_in = qq;
        @(posedge clock);
        #1;
        modelStep(en, st, ii, qq);
        checkOutput("cycle");
        if (out_strobe) begin
            gotQ.push_back({i_out, q_out});
            strobeCount++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic sendRandom();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        b = 16'($urandom);
        if (a == 16'h8000 && b == 16'h8000) b = 16'h0001;
        applyStimulus(1'b1, 1'b1, a, b);
    endtask

    // Disable for one cycle, then let the block move from IDLE into FILL
    task automatic restart();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
    endtask

    typedef struct {
        logic [15:0] iWord;
        logic [15:0] qWord;
        logic [15:0] iSigns;
        logic [15:0] qSigns;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int idx;
        int expI;
        int expQ;
        logic [31:0] s;
        logic [15:0] nw1;
        logic [15:0] nw2;

        // iSigns/qSigns: 1 = +AMPLITUDE, 0 = -AMPLITUDE, oldest sample first
        vecs[0] = '{16'hA5F0, 16'h0001, 16'b1010_0101_1111_0000, 16'b0000_0000_0000_0001};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'b1111_1111_1111_1111, 16'b0000_0000_0000_0000};
        vecs[2] = '{16'h0F0F, 16'hFFFE, 16'b0000_1111_0000_1111, 16'b1111_1111_1111_1110};
        vecs[3] = '{16'h8001, 16'h7FFE, 16'b1000_0000_0000_0001, 16'b0111_1111_1111_1110};

        reset = 1'b0;
        enable = 1'b0;
        in_strobe = 1'b0;
        i_in = '0;
        q_in = '0;
        #12;
        modelReset();
        checkOutput("resetState");
        checkVal("resetInReady", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);

        // Table vectors: two words back to back, then one per 16 cycles
        gotQ.delete();
        for (int c = 0; c < 70; c++) begin
            idx = -1;
            if (c == 0) idx = 0;
            else if (c == 1) idx = 1;
            else if (c % 16 == 0 && c / 16 + 1 < 4) idx = c / 16 + 1;
            if (idx >= 0) applyStimulus(1'b1, 1'b1, vecs[idx].iWord, vecs[idx].qWord);
            else applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
            if (c == 1) checkVal("latencyNoStrobeYet", out_strobe, 0);
            if (c == 2) checkVal("latencyFirstStrobe", out_strobe, 1);
        end
        checkVal("tableSampleCount", gotQ.size(), 64);
        checkVal("tableUnderrun", underrun, 1);
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 16; b++) begin
                if (k * 16 + b < gotQ.size()) begin
                    s = gotQ[k * 16 + b];
                    expI = vecs[k].iSigns[15 - b] ? 8192 : -8192;
                    expQ = vecs[k].qSigns[15 - b] ? 8192 : -8192;
                    checkVal("tableI", int'($signed(s[31:16])), expI);
                    checkVal("tableQ", int'($signed(s[15:0])), expQ);
                end
            end
        end

        // Underrun: two words yield exactly 32 samples, then resume on two more
        restart();
        strobeCount = 0;
        sendRandom();
        sendRandom();
        idle(45);
        checkVal("underrunSamples", strobeCount, 32);
        checkVal("underrunFlag", underrun, 1);
        checkVal("underrunStrobeLow", out_strobe, 0);
        sendRandom();
        sendRandom();
        checkVal("resumeNotYet", out_strobe, 0);
        idle(1);
        checkVal("resumeStrobe", out_strobe, 1);
        checkVal("resumeUnderrunSticky", underrun, 1);
        idle(40);

        // Overflow: seven words from FILL, only five fit
        restart();
        strobeCount = 0;
        for (int w = 1; w <= 7; w++) begin
            sendRandom();
            if (w == 4) checkVal("ovfReadyBeforeFull", in_ready, 1);
            if (w == 5) checkVal("ovfReadyLow", in_ready, 0);
            if (w == 5) checkVal("ovfNotYet", overflow, 0);
            if (w == 6) checkVal("ovfFlag", overflow, 1);
        end
        idle(110);
        checkVal("ovfSamples", strobeCount, 80);
        checkVal("ovfUnderrun", underrun, 1);

        // Enable drop during RUN with overflow set
        restart();
        for (int w = 1; w <= 7; w++) sendRandom();
        idle(5);
        checkVal("dropPreOvf", overflow, 1);
        checkVal("dropPreStrobe", out_strobe, 1);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
        checkVal("dropStrobe", out_strobe, 0);
        checkVal("dropI", i_out, 0);
        checkVal("dropOvf", overflow, 0);
        checkVal("dropUnf", underrun, 0);
        checkVal("dropReady", in_ready, 1);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);

        // Marker mid-stream: queued words are discarded, new words restart output
        for (int w = 1; w <= 3; w++) sendRandom();
        idle(2);
        checkVal("markerPreStrobe", out_strobe, 1);
        applyStimulus(1'b1, 1'b1, 16'h8000, 16'h8000);
        checkVal("markerStrobe", out_strobe, 0);
        checkVal("markerI", i_out, 0);
        checkVal("markerQ", q_out, 0);
        checkVal("markerReady", in_ready, 1);
        strobeCount = 0;
        idle(20);
        checkVal("markerNoOldWords", strobeCount, 0);
        nw1 = 16'h8F00;
        nw2 = 16'h1234;
        applyStimulus(1'b1, 1'b1, nw1, 16'h00FF);
        applyStimulus(1'b1, 1'b1, nw2, 16'h4321);
        checkVal("markerRestartNotYet", out_strobe, 0);
        idle(1);
        checkVal("markerRestartStrobe", out_strobe, 1);
        checkVal("markerRestartI", i_out, 8192);
        checkVal("markerRestartQ", q_out, -8192);
        idle(40);

        // Asynchronous reset mid-RUN with overflow set
        restart();
        for (int w = 1; w <= 7; w++) sendRandom();
        idle(3);
        checkVal("arstPreOvf", overflow, 1);
        enable = 1'b1;
        in_strobe = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checkVal("arstStrobe", out_strobe, 0);
        checkVal("arstI", i_out, 0);
        checkVal("arstQ", q_out, 0);
        checkVal("arstUnf", underrun, 0);
        checkVal("arstOvf", overflow, 0);
        checkVal("arstReady", in_ready, 1);
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(1);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic en;
            en = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 99);
            if (r < 2) applyStimulus(en, 1'b1, 16'h8000, 16'h8000);
            else if (r < 9) begin
                enable = en;
                if (en) sendRandom();
                else applyStimulus(1'b0, 1'b1, 16'($urandom), 16'($urandom));
            end else applyStimulus(en, 1'b0, 16'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
